afx_axis_upsize_2to1: RTL and testbench
=======================================

# afx_axis_upsize_2to1

Two-to-one AXI-Stream width upsizer that packs pairs of IN_W-bit beats into one 2*IN_W-bit beat, with frame (tlast) handling and half-word keep. It sits directly upstream of the AXI-Stream skid buffer on the transmit datapath, turning 16-bit link-side words into 32-bit SATA dwords. It also keeps a running count of completed output frames. Outputs are fully registered, and the block sustains one output beat per two input beats with no bubbles.

## Interface
Parameters:
- IN_W, 16, input beat width in bits; output width is 2*IN_W.
- CNT_W, 16, width of the frame counter.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- s_aixs_tdata  in  IN_W  input beat data.
- s_aixs_tlast  in  1  last beat of the input frame.
- s_aixs_tvalid  in  1  input beat valid.
- s_aixs_tready  out  1  block can accept an input beat.
- m_aixs_tdata  out  2*IN_W  packed output data; the first input beat occupies the low half.
- m_aixs_tkeep  out  2  half-word enables; bit0 is the low half, bit1 is the high half.
- m_aixs_tlast  out  1  last output beat of the frame.
- m_aixs_tvalid  out  1  output beat valid.
- m_aixs_tready  in  1  downstream accepts the output beat.
- frame_cnt  out  CNT_W  number of output frames completed (tlast handshakes); wraps modulo 2^CNT_W.

## Operation
- Input handshake (acc): s_aixs_tvalid & s_aixs_tready. Output handshake (ohs): m_aixs_tvalid & m_aixs_tready.
- s_aixs_tready is combinational: ~rst & (~m_aixs_tvalid | m_aixs_tready). It does not depend on s_aixs_tvalid or s_aixs_tlast.
- State machine with two states:
  - EMPTY: no half-word held.
  - HALF: low half held in lo_q.
- EMPTY, acc, tlast=0:
  - lo_q <= tdata.
  - Go to HALF.
  - No output load.
- EMPTY, acc, tlast=1:
  - Load output: tdata = {IN_W'0, s_tdata}, tkeep = 2'b01, tlast = 1, tvalid = 1.
  - Stay in EMPTY.
- HALF, acc:
  - Load output: tdata = {s_tdata, lo_q}, tkeep = 2'b11, tlast = s_tlast, tvalid = 1.
  - Go to EMPTY.
- Output register update rules:
  - If ohs and no load in the same cycle, m_aixs_tvalid <= 0.
  - If ohs and a load occur in the same cycle, the load wins: back-to-back valid.
  - While m_aixs_tvalid=1 and m_aixs_tready=0, all m_* outputs hold stable.
- frame_cnt increments by 1 on every ohs with m_aixs_tlast=1. It wraps from 2^CNT_W-1 to 0.
- Reset values:
  - State = EMPTY, lo_q = 0.
  - m_aixs_tdata = 0, m_aixs_tkeep = 0, m_aixs_tlast = 0, m_aixs_tvalid = 0.
  - frame_cnt = 0.
  - s_aixs_tready = 0 while rst=1.
- Reset mid-frame: a held half-word in HALF is discarded, and a pending output beat is dropped. No partial beat is emitted after reset.
- No keep on the input side. All input beats are full width.

## Timing
- Latency:
  - Second beat of a pair accepted in cycle N gives m_aixs_tvalid=1 in cycle N+1.
  - Odd tlast beat accepted in cycle N gives output in N+1.
- Throughput with m_aixs_tready held 1: s_aixs_tready stays 1 continuously, and one output beat is produced per two input beats.
- Backpressure: with an output beat pending and m_aixs_tready=0, s_aixs_tready=0. This applies even in EMPTY, so a possible tlast beat always has a free slot.
- After m_aixs_tready deasserts and later re-asserts, the stalled beat is delivered first. A load in that same cycle follows in the next cycle.
- frame_cnt updates in the cycle after the tlast ohs edge, registered.

## Test plan
- Reset check: hold rst=1 for 3 cycles while tvalid=1 -> s_aixs_tready=0, m_aixs_tvalid=0, frame_cnt=0, and no beats are accepted.
- Even frame: input 0x1111, 0x2222, 0x3333, 0x4444 (tlast on 0x4444), m_tready=1 -> outputs 0x22221111 keep 11 last 0, then 0x44443333 keep 11 last 1. frame_cnt=1. s_tready stays 1 throughout.
- Odd frame: input 0xAAAA, 0xBBBB, 0xCCCC (tlast on 0xCCCC) -> outputs 0xBBBBAAAA keep 11 last 0, then 0x0000CCCC keep 01 last 1.
- Single-beat frames back-to-back: 0x0001(last), 0x0002(last) -> outputs 0x00000001 keep 01 last 1, then 0x00000002 keep 01 last 1, on consecutive cycles. frame_cnt=2.
- Backpressure: stream an 8-beat frame 0x0000..0x0007 while m_tready toggles randomly -> exactly 4 outputs, 0x00010000, 0x00030002, 0x00050004, 0x00070006, in order with no loss or duplication. m_* stay stable while stalled, and s_tready=0 whenever m_tvalid=1 and m_tready=0.
- Reset mid-frame: accept 0x5555 (HALF), assert rst for 1 cycle, then send 0x6666, 0x7777(last) -> single output 0x77776666 keep 11 last 1. 0x5555 never appears. Counter wrap with CNT_W=2: 5 frames -> frame_cnt=1.

Source files
------------

// File: rtl/afx_axis_upsize_2to1.sv
// afx_axis_upsize_2to1
// Packs pairs of IN_W-bit AXI-Stream beats into one 2*IN_W-bit beat.
// The first beat of a pair goes in the low half. An odd final beat of a frame
// is emitted alone with only the low half kept. All outputs are registered.
// The block also counts completed output frames, wrapping modulo 2^CNT_W.
//
// state | meaning
// ------+--------------------------------------------
// EMPTY | no half-word held
// HALF  | low half-word held in lo_q, waiting for its pair
module afx_axis_upsize_2to1 #(
    parameter int IN_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   s_aixs_tdata,
    input  logic              s_aixs_tlast,
    input  logic              s_aixs_tvalid,
    output logic              s_aixs_tready,
    output logic [2*IN_W-1:0] m_aixs_tdata,
    output logic [1:0]        m_aixs_tkeep,
    output logic              m_aixs_tlast,
    output logic              m_aixs_tvalid,
    input  logic              m_aixs_tready,
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IN_W-1:0]     lo_q;
    logic [IN_W-1:0]     lo_d;
    logic                acc;
    logic                ohs;
    logic                load;
    logic [2*IN_W-1:0]   load_data;
    logic [1:0]          load_keep;
    logic                load_last;

    // The output slot is always free when we accept, so an odd tlast beat
    // in EMPTY can be loaded immediately without needing extra storage.
    assign s_aixs_tready = ~rst & (~m_aixs_tvalid | m_aixs_tready);
    assign acc           = s_aixs_tvalid & s_aixs_tready;
    assign ohs           = m_aixs_tvalid & m_aixs_tready;

    // Next-state and output-load decode
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        load      = 1'b0;
        load_data = '0;
        load_keep = 2'b00;
        load_last = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    if (s_aixs_tlast) begin
                        load      = 1'b1;
                        load_data = {{IN_W{1'b0}}, s_aixs_tdata};
                        load_keep = 2'b01;
                        load_last = 1'b1;
                    end else begin
                        lo_d    = s_aixs_tdata;
                        state_d = HALF;
                    end
                end
            end
            HALF: begin
                if (acc) begin
                    load      = 1'b1;
                    load_data = {s_aixs_tdata, lo_q};
                    load_keep = 2'b11;
                    load_last = s_aixs_tlast;
                    state_d   = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and held half-word; reset discards any partial pair
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
        end
    end

    // Output register: a load overrides a same-cycle handshake, giving back-to-back beats
    always_ff @(posedge clk) begin
        if (rst) begin
            m_aixs_tdata  <= '0;
            m_aixs_tkeep  <= 2'b00;
            m_aixs_tlast  <= 1'b0;
            m_aixs_tvalid <= 1'b0;
        end else if (load) begin
            m_aixs_tdata  <= load_data;
            m_aixs_tkeep  <= load_keep;
            m_aixs_tlast  <= load_last;
            m_aixs_tvalid <= 1'b1;
        end else if (ohs) begin
            m_aixs_tvalid <= 1'b0;
        end
    end

    // Completed-frame counter, bumped on each tlast handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (ohs && m_aixs_tlast) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_afx_axis_upsize_2to1.sv
// Testbench for afx_axis_upsize_2to1: directed frames checked against a
// frame-level packing model plus literal expectations per scenario.
module tb_afx_axis_upsize_2to1;

    localparam int IN_W  = 16;
    localparam int CNT_W = 2;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  k;
        logic        l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [IN_W-1:0]   s_tdata = '0;
    logic              s_tlast = 1'b0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [2*IN_W-1:0] m_tdata;
    logic [1:0]        m_tkeep;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [CNT_W-1:0]  frame_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stall_cnt = 0;
    bit bp_en = 1'b0;

    logic [IN_W-1:0] frm[$];
    beat_t exp_q[$];
    int    exp_frames = 0;
    beat_t log_q[$];
    int    log_cyc[$];

    bit          prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [1:0]  prev_k;
    logic        prev_l;

    afx_axis_upsize_2to1 #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_aixs_tdata  (s_tdata),
        .s_aixs_tlast  (s_tlast),
        .s_aixs_tvalid (s_tvalid),
        .s_aixs_tready (s_tready),
        .m_aixs_tdata  (m_tdata),
        .m_aixs_tkeep  (m_tkeep),
        .m_aixs_tlast  (m_tlast),
        .m_aixs_tvalid (m_tvalid),
        .m_aixs_tready (m_tready),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (bp_en) begin
            #1 m_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the frame model
    always @(negedge clk) begin
        chk("s_tready_rule", {31'b0, s_tready}, {31'b0, ~rst & (~m_tvalid | m_tready)});
        if (rst) begin
            frm.delete();
            exp_q.delete();
            exp_frames = 0;
            prev_stall = 1'b0;
        end else begin
            chk("frame_cnt_model", {30'b0, frame_cnt}, {30'b0, exp_frames[CNT_W-1:0]});
            if (prev_stall) begin
                chk("stall_valid", {31'b0, m_tvalid}, 32'd1);
                chk("stall_data", m_tdata, prev_d);
                chk("stall_keep", {30'b0, m_tkeep}, {30'b0, prev_k});
                chk("stall_last", {31'b0, m_tlast}, {31'b0, prev_l});
            end
            if (m_tvalid && m_tready) begin
                beat_t b;
                b.d = m_tdata; b.k = m_tkeep; b.l = m_tlast;
                log_q.push_back(b);
                log_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got 0x%0h with nothing expected", m_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("model_data", m_tdata, e.d);
                    chk("model_keep", {30'b0, m_tkeep}, {30'b0, e.k});
                    chk("model_last", {31'b0, m_tlast}, {31'b0, e.l});
                end
                if (m_tlast) exp_frames++;
            end
            if (s_tvalid && s_tready) begin
                beat_t e;
                frm.push_back(s_tdata);
                if (frm.size() == 2) begin
                    e.d = {frm[1], frm[0]}; e.k = 2'b11; e.l = s_tlast;
                    exp_q.push_back(e);
                    frm.delete();
                end else if (s_tlast) begin
                    e.d = {16'h0000, frm[0]}; e.k = 2'b01; e.l = 1'b1;
                    exp_q.push_back(e);
                    frm.delete();
                end
            end
            prev_stall = m_tvalid & ~m_tready;
            prev_d = m_tdata; prev_k = m_tkeep; prev_l = m_tlast;
        end
    end

    task automatic send(input logic [15:0] d, input logic l);
        bit ok = 1'b0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = s_tready;
            if (!ok) stall_cnt++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: beat 0x%0h never accepted", d);
        end
    endtask

    task automatic idle();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = !m_tvalid;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL drain_timeout: m_tvalid stuck at 1");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        log_q.delete();
        log_cyc.delete();
        stall_cnt = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_out(input string name, input int idx, input logic [31:0] d,
                           input logic [1:0] k, input logic l);
        if (idx >= log_q.size()) begin
            total++; bad++;
            $display("FAIL %s: output %0d missing, got only %0d", name, idx, log_q.size());
        end else begin
            chk({name, "_data"}, log_q[idx].d, d);
            chk({name, "_keep"}, {30'b0, log_q[idx].k}, {30'b0, k});
            chk({name, "_last"}, {31'b0, log_q[idx].l}, {31'b0, l});
        end
    endtask

    initial begin
        // Reset held with a valid beat offered
        s_tvalid = 1'b1; s_tdata = 16'h9999; s_tlast = 1'b1;
        start_test();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_s_tready", {31'b0, s_tready}, 32'd0);
            chk("rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
            chk("rst_frame_cnt", {30'b0, frame_cnt}, 32'd0);
        end
        idle();
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_output", log_q.size(), 32'd0);

        // Even frame
        start_test();
        send(16'h1111, 1'b0); send(16'h2222, 1'b0);
        send(16'h3333, 1'b0); send(16'h4444, 1'b1);
        idle(); drain();
        chk("even_count", log_q.size(), 32'd2);
        chk_out("even0", 0, 32'h22221111, 2'b11, 1'b0);
        chk_out("even1", 1, 32'h44443333, 2'b11, 1'b1);
        chk("even_frame_cnt", {30'b0, frame_cnt}, 32'd1);
        chk("even_no_stall", stall_cnt, 32'd0);

        // Odd frame
        start_test();
        send(16'hAAAA, 1'b0); send(16'hBBBB, 1'b0); send(16'hCCCC, 1'b1);
        idle(); drain();
        chk("odd_count", log_q.size(), 32'd2);
        chk_out("odd0", 0, 32'hBBBBAAAA, 2'b11, 1'b0);
        chk_out("odd1", 1, 32'h0000CCCC, 2'b01, 1'b1);
        chk("odd_frame_cnt", {30'b0, frame_cnt}, 32'd2);

        // Single-beat frames back-to-back from a clean counter
        do_reset();
        start_test();
        send(16'h0001, 1'b1); send(16'h0002, 1'b1);
        idle(); drain();
        chk("single_count", log_q.size(), 32'd2);
        chk_out("single0", 0, 32'h00000001, 2'b01, 1'b1);
        chk_out("single1", 1, 32'h00000002, 2'b01, 1'b1);
        if (log_cyc.size() == 2) chk("single_consecutive", log_cyc[1] - log_cyc[0], 32'd1);
        chk("single_frame_cnt", {30'b0, frame_cnt}, 32'd2);

        // Random backpressure on an 8-beat frame
        start_test();
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) send(16'(i), i == 7);
        idle();
        repeat (6) @(posedge clk);
        bp_en = 1'b0;
        @(posedge clk);
        #2 m_tready = 1'b1;
        drain();
        chk("bp_count", log_q.size(), 32'd4);
        chk_out("bp0", 0, 32'h00010000, 2'b11, 1'b0);
        chk_out("bp1", 1, 32'h00030002, 2'b11, 1'b0);
        chk_out("bp2", 2, 32'h00050004, 2'b11, 1'b0);
        chk_out("bp3", 3, 32'h00070006, 2'b11, 1'b1);
        chk("bp_frame_cnt", {30'b0, frame_cnt}, 32'd3);

        // Reset with a half-word held
        start_test();
        send(16'h5555, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(16'h6666, 1'b0); send(16'h7777, 1'b1);
        idle(); drain();
        chk("midrst_count", log_q.size(), 32'd1);
        chk_out("midrst0", 0, 32'h77776666, 2'b11, 1'b1);
        chk("midrst_frame_cnt", {30'b0, frame_cnt}, 32'd1);

        // Counter wrap: five frames on a 2-bit counter
        do_reset();
        start_test();
        for (int i = 0; i < 5; i++) send(16'h0100 + 16'(i), 1'b1);
        idle(); drain();
        chk("wrap_count", log_q.size(), 32'd5);
        chk_out("wrap4", 4, 32'h00000104, 2'b01, 1'b1);
        chk("wrap_frame_cnt", {30'b0, frame_cnt}, 32'd1);

        chk("model_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
